output_deskew_buffer: RTL and testbench

Collects results leaving the bottom edge of the systolic array. Each column is skewed: column j is valid one cycle after column j-1. The block removes that skew with per-column delay lines, so that all columns of one result row line up. Aligned rows go into a small row FIFO, which a downstream consumer drains through a valid/ready handshake. It is the drain-side counterpart of the skewing input buffer that feeds the array.

---
 rtl/output_deskew_buffer.sv | 138 +++++++++++++
 tb/tb_output_deskew_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_deskew_buffer.sv
// Output deskew buffer: realigns the diagonally skewed results leaving the
// systolic array into whole rows, then queues them in a show-ahead row FIFO
// for a valid/ready consumer. Column j is delayed ARRAYWIDTH-1-j cycles and
// then lands in a common align register, so one row lines up in one cycle.
module output_deskew_buffer #(
  parameter int ARRAYWIDTH = 4,
  parameter int OUTSIZE    = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - ARRAYWIDTH - 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic [ARRAYWIDTH-1:0]            in_valid,
  input  logic [ARRAYWIDTH*OUTSIZE-1:0]    in_res,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAYWIDTH*OUTSIZE-1:0]    out_res,
  output logic                             almost_full,
  output logic [$clog2(FIFO_DEPTH):0]      count,
  output logic                             overflow,
  output logic                             skew_err
);

  localparam int RW = ARRAYWIDTH * OUTSIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  // Per-column delay line outputs, all arriving in the same cycle.
  logic [ARRAYWIDTH-1:0] col_v;
  logic [RW-1:0]         col_d;

  for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_col
    localparam int D = ARRAYWIDTH - 1 - j;
    if (D == 0) begin : g_direct
      assign col_v[j]                     = in_valid[j];
      assign col_d[j*OUTSIZE +: OUTSIZE]  = in_res[j*OUTSIZE +: OUTSIZE];
    end else begin : g_dly
      logic [D-1:0]       dv;
      logic [OUTSIZE-1:0] dd [D];

      // Valid shift chain; flushed by clear so in-flight partial rows vanish.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dv <= '0;
        end else if (clear) begin
          dv <= '0;
        end else begin
          dv[0] <= in_valid[j];
          for (int k = 1; k < D; k++) dv[k] <= dv[k-1];
        end
      end

      // Data shift chain; qualified by the valid chain so it needs no reset.
      always_ff @(posedge clk) begin
        dd[0] <= in_res[j*OUTSIZE +: OUTSIZE];
        for (int k = 1; k < D; k++) dd[k] <= dd[k-1];
      end

      assign col_v[j]                    = dv[D-1];
      assign col_d[j*OUTSIZE +: OUTSIZE] = dd[D-1];
    end
  end

  logic [ARRAYWIDTH-1:0] al_v;
  logic [RW-1:0]         al_d;

  // Common align register valids: one whole row is visible here per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      al_v <= '0;
    end else if (clear) begin
      al_v <= '0;
    end else begin
      al_v <= col_v;
    end
  end

  // Align register data.
  always_ff @(posedge clk) begin
    al_d <= col_d;
  end

  logic          wr_req, mixed, full, pop, wr_ok, drop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [RW-1:0] mem [FIFO_DEPTH];

  assign wr_req = &al_v;
  assign mixed  = (|al_v) & ~wr_req;
  assign full   = (count == DEPTH_C);
  assign pop    = out_valid & out_ready;
  // At full, a simultaneous pop frees the slot the write lands in.
  assign wr_ok  = wr_req & (~full | pop);
  assign drop   = wr_req & full & ~pop;

  // Row storage; cleared on reset so an empty FIFO reads zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (!clear && wr_ok) begin
      mem[wr_ptr] <= al_d;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)  overflow <= 1'b1;
      if (mixed) skew_err <= 1'b1;
    end
  end

  assign out_valid   = (count != '0);
  assign out_res     = mem[rd_ptr];
  assign almost_full = (count >= AF_C);

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Bench for output_deskew_buffer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// row-level model (slots keyed by arrival time, a queue for the FIFO).
module tb_output_deskew_buffer;
  localparam int W     = 4;
  localparam int OS    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - W - 1;
  localparam int RW    = W * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_valid = '0;
  logic [RW-1:0] in_res = '0;
  logic          out_valid;
  logic [RW-1:0] out_res;
  logic          almost_full;
  logic [3:0]    count;
  logic          overflow;
  logic          skew_err;

  always #5 clk = ~clk;

  output_deskew_buffer #(
    .ARRAYWIDTH(W), .OUTSIZE(OS), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .skew_err(skew_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus schedule (per future cycle) ----------------
  logic [W-1:0]  sch_v [16];
  logic [RW-1:0] sch_d [16];
  int tc = 0;

  task automatic clear_sched();
    for (int i = 0; i < 16; i++) begin
      sch_v[i] = '0;
      sch_d[i] = '0;
    end
  endtask

  // Column j of a row issued now is presented j cycles later.
  task automatic issue_mask(input logic [W-1:0] mask, input logic [RW-1:0] row);
    for (int j = 0; j < W; j++) begin
      if (mask[j]) begin
        sch_v[(tc + j) % 16][j] = 1'b1;
        sch_d[(tc + j) % 16][j*OS +: OS] = row[j*OS +: OS];
      end
    end
  endtask

  task automatic issue_row(input logic [RW-1:0] row);
    issue_mask({W{1'b1}}, row);
  endtask

  task automatic cyc_start();
    in_valid = sch_v[tc % 16];
    in_res   = sch_d[tc % 16];
    sch_v[tc % 16] = '0;
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
    tc++;
  endtask

  function automatic logic [RW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- behavioural model ----------------
  // slot_v/slot_d[c % 16] hold whatever parts of a row are due to be aligned
  // in cycle c (column j entering in cycle t is due in cycle t + W - j).
  logic [RW-1:0] mq [$];
  logic [W-1:0]  slot_v [16];
  logic [RW-1:0] slot_d [16];
  logic          m_ovf = 1'b0;
  logic          m_skew = 1'b0;
  logic          fresh = 1'b1;
  int            m_cyc = 0;
  logic [W-1:0]  a_v;
  logic [RW-1:0] a_d;
  logic          do_pop, do_push;
  int            s;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_skew = 1'b0;
      fresh  = 1'b1;
      for (int i = 0; i < 16; i++) begin
        slot_v[i] = '0;
        slot_d[i] = '0;
      end
    end else begin
      a_v = slot_v[m_cyc % 16];
      a_d = slot_d[m_cyc % 16];
      slot_v[m_cyc % 16] = '0;
      if (clear) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_skew = 1'b0;
        for (int i = 0; i < 16; i++) slot_v[i] = '0;
      end else begin
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = 1'b0;
        if (a_v == {W{1'b1}}) begin
          if (mq.size() < DEPTH || do_pop) do_push = 1'b1;
          else m_ovf = 1'b1;
        end else if (a_v != '0) begin
          m_skew = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back(a_d);
          fresh = 1'b0;
        end
        for (int j = 0; j < W; j++) begin
          if (in_valid[j]) begin
            s = (m_cyc + W - j) % 16;
            slot_v[s][j] = 1'b1;
            slot_d[s][j*OS +: OS] = in_res[j*OS +: OS];
          end
        end
      end
    end
    m_cyc++;
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("out_valid", RW'(out_valid), RW'(mq.size() != 0));
    chk("count", RW'(count), RW'(mq.size()));
    chk("almost_full", RW'(almost_full), RW'(mq.size() >= AF));
    chk("overflow", RW'(overflow), RW'(m_ovf));
    chk("skew_err", RW'(skew_err), RW'(m_skew));
    if (mq.size() != 0) chk("out_res", out_res, mq[0]);
    else if (fresh) chk("out_res_empty", out_res, '0);
  end

  // ---------------- directed helpers ----------------
  int            npop;
  int            maxc;
  logic [RW-1:0] lastp;
  logic [RW-1:0] ovr [10];
  logic [RW-1:0] stream [20];
  logic [RW-1:0] nr;

  task automatic single_row(input string tag);
    logic [RW-1:0] r;
    r = {32'h13, 32'h12, 32'h11, 32'h10};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) issue_row(r);
      cyc_start();
      @(negedge clk);
      chk({tag, "_valid"}, RW'(out_valid), RW'(k == 5));
      if (k == 5) chk({tag, "_res"}, out_res, r);
      cyc_end();
    end
    cyc_start();
    @(negedge clk);
    chk({tag, "_count0"}, RW'(count), RW'(0));
    cyc_end();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc_start();
    cyc_end();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_sched();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", RW'(out_valid), RW'(0));
    chk("rst_count", RW'(count), RW'(0));
    chk("rst_res", out_res, '0);
    chk("rst_flags", RW'({overflow, skew_err, almost_full}), RW'(0));
    rst = 1'b1;

    // Single row latency.
    single_row("t1");

    // Ten rows into a stalled FIFO: fill, almost_full, overflow, then drain.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < 10) begin
        ovr[k] = rand_row();
        issue_row(ovr[k]);
      end
      cyc_start();
      @(negedge clk);
      if (k == 6) chk("t2_af_at2", RW'({count, almost_full}), RW'({4'd2, 1'b0}));
      if (k == 7) chk("t2_af_at3", RW'({count, almost_full}), RW'({4'd3, 1'b1}));
      if (k == 15) chk("t2_full", RW'({count, overflow}), RW'({4'd8, 1'b1}));
      cyc_end();
    end
    out_ready = 1'b1;
    npop = 0;
    for (int k = 0; k < 10; k++) begin
      cyc_start();
      @(negedge clk);
      if (out_valid && npop < 10) begin
        chk("t2_order", out_res, ovr[npop]);
        npop++;
      end
      cyc_end();
    end
    chk("t2_npop", RW'(npop), RW'(8));

    // Full FIFO with write and pop in the same cycle.
    pulse_clear();
    for (int k = 0; k < 15; k++) begin
      out_ready = (k == 12);
      if (k < 8) issue_row(rand_row());
      if (k == 8) begin
        nr = rand_row();
        issue_row(nr);
      end
      cyc_start();
      @(negedge clk);
      if (k == 0) chk("t3_cleared", RW'({count, overflow}), RW'(0));
      if (k == 12) chk("t3_full", RW'(count), RW'(8));
      if (k == 13) chk("t3_wrpop", RW'({count, overflow}), RW'({4'd8, 1'b0}));
      cyc_end();
    end
    out_ready = 1'b1;
    npop = 0;
    for (int k = 0; k < 10; k++) begin
      cyc_start();
      @(negedge clk);
      if (out_valid) begin
        lastp = out_res;
        npop++;
      end
      cyc_end();
    end
    chk("t3_npop", RW'(npop), RW'(8));
    chk("t3_last", lastp, nr);

    // Only column 2 valid: skew error, nothing stored; clear drops the flag.
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) issue_mask(4'b0100, rand_row());
      cyc_start();
      @(negedge clk);
      cyc_end();
    end
    cyc_start();
    @(negedge clk);
    chk("t4_skew", RW'({skew_err, count}), RW'({1'b1, 4'd0}));
    cyc_end();
    pulse_clear();
    cyc_start();
    @(negedge clk);
    chk("t4_skew_clr", RW'(skew_err), RW'(0));
    cyc_end();

    // Stream of 20 rows with out_ready toggling.
    npop = 0;
    maxc = 0;
    for (int k = 0; k < 50; k++) begin
      out_ready = (k % 2 == 0);
      if (k % 2 == 0 && k < 40) begin
        stream[k/2] = rand_row();
        issue_row(stream[k/2]);
      end
      cyc_start();
      @(negedge clk);
      if (int'(count) > maxc) maxc = int'(count);
      if (out_valid && out_ready && npop < 20) begin
        chk("t5_order", out_res, stream[npop]);
        npop++;
      end
      cyc_end();
    end
    chk("t5_npop", RW'(npop), RW'(20));
    chk("t5_maxc", RW'(maxc <= 2), RW'(1));

    // Async reset with rows buffered and in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k == 0 || k == 1 || k == 2 || k == 8 || k == 9) issue_row(rand_row());
      cyc_start();
      @(negedge clk);
      if (k == 9) chk("t6_buffered", RW'(count), RW'(3));
      if (k == 10) begin
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async", RW'({out_valid, count, almost_full, overflow, skew_err}), RW'(0));
        clear_sched();
        in_valid = '0;
      end
      cyc_end();
    end
    rst = 1'b1;
    single_row("t6");

    // Clear coincident with a row write.
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      clear = (k == 4);
      if (k == 0) issue_row(rand_row());
      cyc_start();
      @(negedge clk);
      if (k == 5) chk("t7_clear_wr", RW'({out_valid, count}), RW'(0));
      cyc_end();
    end
    clear = 1'b0;

    // Randomized traffic checked by the model.
    for (int k = 0; k < 800; k++) begin
      int r;
      clear = ($urandom % 64 == 0);
      out_ready = (k < 400) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      r = $urandom % 8;
      if (r < 5) issue_row(rand_row());
      else if (r == 5 && $urandom % 4 == 0) issue_mask(4'($urandom_range(1, 14)), rand_row());
      cyc_start();
      @(negedge clk);
      cyc_end();
    end
    clear = 1'b0;
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
